// File: rtl/adpll_ctrl_pkg.sv
// Shared types, widths and helpers for the ADPLL speed-change sequencer.
package adpll_ctrl_pkg;

  localparam int unsigned SPEED_W = 10;

  localparam logic [SPEED_W-1:0] SPD_MIN = 10'd0;
  localparam logic [SPEED_W-1:0] SPD_MAX = 10'd1000;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    WAIT_LOCK,
    DONE
  } spd_state_e;

  // One ramp step from cur toward tgt, limited to step; the 11-bit difference
  // keeps the move from overshooting or wrapping.
  function automatic logic [SPEED_W-1:0] step_toward(
    input logic [SPEED_W-1:0] tgt,
    input logic [SPEED_W-1:0] cur,
    input logic [SPEED_W:0]   step
  );
    logic [SPEED_W:0] diff;
    logic [SPEED_W:0] nxt;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      nxt  = (diff <= step) ? {1'b0, tgt} : ({1'b0, cur} + step);
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      nxt  = (diff <= step) ? {1'b0, tgt} : ({1'b0, cur} - step);
    end
    return SPEED_W'(nxt);
  endfunction

endpackage

// File: rtl/adpll_dly_cnt.sv
// Loadable down-counter with zero flag; times both the settle and lock-wait intervals.
module adpll_dly_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         REF_CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge REF_CLK) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adpll_speed_ctrl.sv
// ADPLL speed-change sequencer: ramps speed toward a requested target, then waits for lock.
// Optional request clamping to [SPD_MIN,SPD_MAX] with req_clamped output: define ADPLL_SPD_CLAMP_EN.
module adpll_speed_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned        STEP_SIZE     = 16,
  parameter int unsigned        SETTLE_CYCLES = 8,
  parameter int unsigned        LOCK_TIMEOUT  = 64,
  parameter logic [SPEED_W-1:0] RESET_SPEED   = 10'd100
) (
  input  logic               REF_CLK,
  input  logic               RESET,
  input  logic               req_valid,
  input  logic [SPEED_W-1:0] req_speed,
  output logic               req_ready,
  input  logic               ADPLL_LOCK,
  output logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               clk_en
`ifdef ADPLL_SPD_CLAMP_EN
  ,
  output logic               req_clamped
`endif
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [SPEED_W:0]   STEP_V     = (SPEED_W + 1)'(STEP_SIZE);

  spd_state_e         state, state_n;
  logic [SPEED_W-1:0] target, target_n, speed_n, req_tgt;
  logic               err_n, clk_en_n, accept;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_ld_val;

  assign accept = req_valid && req_ready;

`ifdef ADPLL_SPD_CLAMP_EN
  logic req_oob;
  assign req_oob = (req_speed > SPD_MAX) || (req_speed < SPD_MIN);
  assign req_tgt = (req_speed > SPD_MAX) ? SPD_MAX :
                   (req_speed < SPD_MIN) ? SPD_MIN : req_speed;

  always_ff @(posedge REF_CLK) begin
    if (!RESET) req_clamped <= 1'b0;
    else        req_clamped <= accept && req_oob;
  end
`else
  assign req_tgt = req_speed;
`endif

  // Only STEP loads the settle interval; every other load starts the lock wait.
  assign cnt_ld_val = (state == STEP) ? SETTLE_LD : TIMEOUT_LD;

  adpll_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .REF_CLK  (REF_CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    target_n = target;
    speed_n  = speed;
    err_n    = err_timeout;
    clk_en_n = clk_en;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        clk_en_n = ADPLL_LOCK;
        if (accept) begin
          target_n = req_tgt;
          err_n    = 1'b0;
          clk_en_n = 1'b0;
          if (req_tgt == speed) begin
            state_n  = WAIT_LOCK;
            cnt_load = 1'b1;
          end else begin
            state_n = STEP;
          end
        end
      end
      STEP: begin
        speed_n  = step_toward(target, speed, STEP_V);
        cnt_load = 1'b1;
        state_n  = SETTLE;
      end
      SETTLE: begin
        if (cnt_zero) begin
          if (speed != target) begin
            state_n = STEP;
          end else begin
            state_n  = WAIT_LOCK;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (ADPLL_LOCK) begin
          state_n  = DONE;
          clk_en_n = 1'b1;
        end else if (cnt_zero) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        clk_en_n = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge REF_CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      speed       <= RESET_SPEED;
      target      <= RESET_SPEED;
      err_timeout <= 1'b0;
      clk_en      <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      speed       <= speed_n;
      target      <= target_n;
      err_timeout <= err_n;
      clk_en      <= clk_en_n;
      req_ready   <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_adpll_speed_ctrl.sv
// Scoreboard bench for adpll_speed_ctrl: expected speed steps and outcomes are queued per request.
module tb_adpll_speed_ctrl;

  localparam int STEP    = 16;
  localparam int SETL    = 8;
  localparam int TMO     = 64;
  localparam int RST_SPD = 100;
  localparam int NEVER   = -1;
  localparam int ABORT   = -2;

  logic       REF_CLK    = 1'b0;
  logic       RESET      = 1'b0;
  logic       req_valid  = 1'b0;
  logic       ADPLL_LOCK = 1'b0;
  logic [9:0] req_speed  = '0;
  logic       req_ready, busy, done, err_timeout, clk_en;
  logic [9:0] speed;
`ifdef ADPLL_SPD_CLAMP_EN
  logic       req_clamped;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int model_speed = RST_SPD;

  typedef struct { int val; int cyc; } spd_ev_t;
  typedef struct { bit tmo; int cyc; } out_ev_t;
  spd_ev_t exp_spd[$];
  out_ev_t exp_out[$];

  adpll_speed_ctrl #(
    .STEP_SIZE    (STEP),
    .SETTLE_CYCLES(SETL),
    .LOCK_TIMEOUT (TMO),
    .RESET_SPEED  (10'd100)
  ) dut (
    .REF_CLK    (REF_CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_speed  (req_speed),
    .req_ready  (req_ready),
    .ADPLL_LOCK (ADPLL_LOCK),
    .speed      (speed),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .clk_en     (clk_en)
`ifdef ADPLL_SPD_CLAMP_EN
    ,
    .req_clamped(req_clamped)
`endif
  );

  always #5 REF_CLK = ~REF_CLK;
  always @(posedge REF_CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a speed change, done or timeout.
  logic [9:0] prev_speed = '0;
  logic       prev_err   = 1'b0;
  logic       prev_done  = 1'b0;
  always @(negedge REF_CLK) begin
    spd_ev_t sev;
    out_ev_t oev;
    if (RESET) begin
      if (speed != prev_speed) begin
        if (exp_spd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL speed_unexpected: got %0d, expected no change (cycle %0d)", speed, cyc);
        end else begin
          sev = exp_spd.pop_front();
          check("speed_value", int'(speed), sev.val);
          check("speed_cycle", cyc, sev.cyc);
        end
      end
      if (prev_done) check("done_width", int'(done), 0);
      if (done && !prev_done) begin
        if (exp_out.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          oev = exp_out.pop_front();
          check("outcome_is_timeout", int'(oev.tmo), 0);
          check("done_cycle", cyc, oev.cyc);
          check("clk_en_at_done", int'(clk_en), 1);
        end
      end
      if (err_timeout && !prev_err) begin
        if (exp_out.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL timeout_unexpected: got err_timeout=1, expected 0 (cycle %0d)", cyc);
        end else begin
          oev = exp_out.pop_front();
          check("outcome_is_timeout", int'(oev.tmo), 1);
          check("timeout_cycle", cyc, oev.cyc);
          check("clk_en_at_timeout", int'(clk_en), 0);
        end
      end
    end
    prev_speed = speed;
    prev_err   = err_timeout;
    prev_done  = done;
  end

  // j: WAIT_LOCK cycles before lock rises (NEVER = timeout, ABORT = return after acceptance).
  task automatic do_req(input int tgt, input int j, input bit held, input int hold_tgt,
                        output int e, output int fin);
    int t_eff, cur, n, w, guard;
    bit cl;
    spd_ev_t sev;
    out_ev_t oev;
    t_eff = tgt;
    cl    = 1'b0;
`ifdef ADPLL_SPD_CLAMP_EN
    if (tgt > 1000) begin
      t_eff = 1000;
      cl    = 1'b1;
    end
`endif
    if (!held) begin
      req_valid = 1'b1;
      req_speed = 10'(tgt);
    end
    guard = 0;
    while (req_ready !== 1'b1) begin
      @(negedge REF_CLK);
      guard++;
      if (guard > 5000) begin
        n_checks++; n_fail++;
        $display("FAIL ready_wait: got req_ready=0 for %0d cycles, expected 1", guard);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "req_ready never returned");
      end
    end
    e = cyc + 1;
    cur = model_speed;
    n = 0;
    while (cur != t_eff) begin
      if (t_eff > cur) cur = (t_eff - cur > STEP) ? cur + STEP : t_eff;
      else             cur = (cur - t_eff > STEP) ? cur - STEP : t_eff;
      n++;
      sev.val = cur;
      sev.cyc = e + 1 + (n - 1) * (SETL + 1);
      exp_spd.push_back(sev);
    end
    model_speed = t_eff;
    w = e + n * (SETL + 1);
    if (j >= 0 && j < TMO) begin
      oev.tmo = 1'b0; oev.cyc = w + j + 1; exp_out.push_back(oev);
    end else if (j != ABORT) begin
      oev.tmo = 1'b1; oev.cyc = w + TMO; exp_out.push_back(oev);
    end
    @(negedge REF_CLK);
    req_valid  = 1'b0;
    ADPLL_LOCK = 1'b0;
    check("accept_busy", int'(busy), 1);
    check("accept_req_ready", int'(req_ready), 0);
    check("accept_err_cleared", int'(err_timeout), 0);
    check("accept_clk_en", int'(clk_en), 0);
`ifdef ADPLL_SPD_CLAMP_EN
    check("req_clamped", int'(req_clamped), int'(cl));
`endif
    fin = e;
    if (j == ABORT) return;
    if (hold_tgt >= 0) begin
      while (cyc < e + 5) @(negedge REF_CLK);
      req_valid = 1'b1;
      req_speed = 10'(hold_tgt);
      check("busy_req_ready", int'(req_ready), 0);
    end
    if (j >= 0 && j < TMO) begin
      while (cyc < w + j) @(negedge REF_CLK);
      ADPLL_LOCK = 1'b1;
      while (cyc < w + j + 1) @(negedge REF_CLK);
      fin = w + j + 1;
    end else begin
      while (cyc < w + TMO) @(negedge REF_CLK);
      fin = w + TMO;
      check("timeout_busy", int'(busy), 0);
      check("timeout_err", int'(err_timeout), 1);
    end
  endtask

  initial begin
    int e, fin, e2, fin2, tgt, j, r;

    // Reset state
    repeat (3) @(negedge REF_CLK);
    check("rst_speed", int'(speed), RST_SPD);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_clk_en", int'(clk_en), 0);
    RESET = 1'b1;
    @(negedge REF_CLK);
    check("idle_no_lock_clk_en", int'(clk_en), 0);
    ADPLL_LOCK = 1'b1;
    @(negedge REF_CLK);
    check("first_lock_clk_en", int'(clk_en), 1);

    // Directed ramps: up, small down, equal, timeout, error clear
    do_req(140, 3, 1'b0, -1, e, fin);
    do_req(130, 2, 1'b0, -1, e, fin);
    do_req(130, 0, 1'b0, -1, e, fin);
    do_req(200, NEVER, 1'b0, -1, e, fin);
    check("timeout_clk_en_held", int'(clk_en), 0);
    do_req(210, 2, 1'b0, -1, e, fin);

    // Request held during a ramp is taken on return to IDLE
    do_req(310, 4, 1'b0, 500, e, fin);
    do_req(500, 1, 1'b1, -1, e2, fin2);
    check("held_accept_cycle", e2, fin + 2);

    // Lock on the final timeout cycle wins; range extremes
    do_req(470, TMO - 1, 1'b0, -1, e, fin);
    do_req(1023, 5, 1'b0, -1, e, fin);
    do_req(0, 2, 1'b0, -1, e, fin);
    do_req(7, 0, 1'b0, -1, e, fin);

    // Random requests
    for (int i = 0; i < 12; i++) begin
      r   = int'($urandom_range(0, 9));
      tgt = (r == 0) ? model_speed : int'($urandom_range(0, 1023));
      r   = int'($urandom_range(0, 9));
      j   = (r < 6) ? int'($urandom_range(0, 10)) : (r < 8) ? TMO - 1 : (r == 8) ? NEVER : 0;
      do_req(tgt, j, 1'b0, -1, e, fin);
      repeat (int'($urandom_range(0, 3))) @(negedge REF_CLK);
    end

    // Lock drop and return while IDLE
    do_req(model_speed, 0, 1'b0, -1, e, fin);
    @(negedge REF_CLK);
    check("idle_locked_clk_en", int'(clk_en), 1);
    ADPLL_LOCK = 1'b0;
    @(negedge REF_CLK);
    check("lock_drop_clk_en", int'(clk_en), 0);
    ADPLL_LOCK = 1'b1;
    @(negedge REF_CLK);
    check("lock_return_clk_en", int'(clk_en), 1);

    // Reset in the middle of a settle interval
    tgt = (model_speed < 512) ? model_speed + 200 : model_speed - 200;
    do_req(tgt, ABORT, 1'b0, -1, e, fin);
    while (cyc < e + 13) @(negedge REF_CLK);
    RESET = 1'b0;
    exp_spd.delete();
    @(negedge REF_CLK);
    check("midrst_speed", int'(speed), RST_SPD);
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err_timeout), 0);
    check("midrst_clk_en", int'(clk_en), 0);
    model_speed = RST_SPD;
    @(negedge REF_CLK);
    RESET = 1'b1;
    ADPLL_LOCK = 1'b1;
    do_req(150, 1, 1'b0, -1, e, fin);

    repeat (4) @(negedge REF_CLK);
    check("speed_queue_drained", exp_spd.size(), 0);
    check("outcome_queue_drained", exp_out.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
